// File: rtl/decode_wave_arbiter.sv
// decode_wave_arbiter
//   Round-robin scheduler that picks which wavefront's buffered instruction
//   dword is presented to decode each slot. When decode reports that the
//   dword it holds needs a second dword, the arbiter re-grants that same
//   wavefront for the second half before resuming round-robin.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   ARB    | scan wave_ready from last_grant+1 (mod NUM_WF) and grant the winner
//   CHECK  | granted dword sits in decode; sample the half-required request
//   SECOND | wait for wave_ready[last_grant], then grant its second dword
//
// Ports
//   clk                 clock, rising edge
//   rst                 synchronous active-high reset
//   wave_ready          per-wavefront "dword buffered" flags
//   wave_ins_half_rqd   decode needs a second dword for the held instruction
//   wave_ins_half_wfid  wavefront the half request refers to
//   arb_valid           registered grant pulse
//   arb_wfid            registered granted wavefront id
//   arb_second_half     registered, high with arb_valid for a second-dword grant
//   arb_error           sticky protocol-violation flag, cleared only by rst

module decode_wave_arbiter #(
    parameter int NUM_WF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] wave_ready,
    input  logic              wave_ins_half_rqd,
    input  logic [5:0]        wave_ins_half_wfid,
    output logic              arb_valid,
    output logic [5:0]        arb_wfid,
    output logic              arb_second_half,
    output logic              arb_error
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        CHECK  = 2'd1,
        SECOND = 2'd2
    } state_t;

    localparam logic [5:0] LAST_WF = 6'(NUM_WF - 1);

    state_t     state, state_next;
    logic [5:0] last_grant, last_grant_next;
    logic       second_pending, second_pending_next;
    logic       valid_next;
    logic [5:0] wfid_next;
    logic       second_half_next;
    logic       error_next;

    logic       found;
    logic [5:0] winner;

    // Rotating priority scan: candidates are last_grant+1 .. last_grant+NUM_WF,
    // so last_grant itself is the lowest-priority (final) candidate.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 1; i <= NUM_WF; i++) begin
            int idx;
            idx = int'(last_grant) + i;
            if (idx >= NUM_WF) begin
                idx = idx - NUM_WF;
            end
            if (!found && wave_ready[idx]) begin
                found  = 1'b1;
                winner = 6'(idx);
            end
        end
    end

    always_comb begin
        state_next          = state;
        last_grant_next     = last_grant;
        second_pending_next = second_pending;
        valid_next          = 1'b0;
        wfid_next           = arb_wfid;
        second_half_next    = 1'b0;
        error_next          = arb_error;

        unique case (state)
            ARB: begin
                if (found) begin
                    valid_next      = 1'b1;
                    wfid_next       = winner;
                    last_grant_next = winner;
                    state_next      = CHECK;
                end
            end
            CHECK: begin
                state_next = ARB;
                if (second_pending) begin
                    // Second dword already delivered; decode's request is stale.
                    second_pending_next = 1'b0;
                end else if (wave_ins_half_rqd) begin
                    // last_grant < NUM_WF, so an out-of-range wfid never matches.
                    if (wave_ins_half_wfid == last_grant) begin
                        state_next = SECOND;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            SECOND: begin
                if (wave_ready[last_grant]) begin
                    valid_next          = 1'b1;
                    wfid_next           = last_grant;
                    second_half_next    = 1'b1;
                    second_pending_next = 1'b1;
                    state_next          = CHECK;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ARB;
            last_grant      <= LAST_WF;
            second_pending  <= 1'b0;
            arb_valid       <= 1'b0;
            arb_wfid        <= '0;
            arb_second_half <= 1'b0;
            arb_error       <= 1'b0;
        end else begin
            state           <= state_next;
            last_grant      <= last_grant_next;
            second_pending  <= second_pending_next;
            arb_valid       <= valid_next;
            arb_wfid        <= wfid_next;
            arb_second_half <= second_half_next;
            arb_error       <= error_next;
        end
    end

endmodule

// File: doc/decode_wave_arbiter.md
# decode_wave_arbiter

Round-robin scheduler that chooses which wavefront's buffered instruction dword goes into the decode stage each slot. It sits between the wavepool instruction buffers and decode. It sequences 64-bit or literal-carrying instructions by re-granting the same wavefront for its second dword when decode raises its half-required request. Outputs are registered and feed decode's wavepool-side instruction valid/wfid selection directly.

## Interface
- NUM_WF, 40: number of wavefront slots; must be ≤ 64 (wfid is 6 bits).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- wave_ready  in  NUM_WF  bit i = wavefront i has an instruction dword buffered and may be granted.
- wave_ins_half_rqd  in  1  decode reports that the dword it holds needs a second dword.
- wave_ins_half_wfid  in  6  wfid that the half request refers to.
- arb_valid  out  1  grant pulse; the wavepool presents dword of arb_wfid to decode this cycle and pops it.
- arb_wfid  out  6  granted wavefront id.
- arb_second_half  out  1  high with arb_valid when the grant is the second dword of a long instruction.
- arb_error  out  1  sticky; set on protocol violation (see Operation).

## Operation
- State machine: ARB, CHECK, SECOND.
- ARB:
  - If any wave_ready bit is set, grant the first set bit found scanning upward from last_grant+1, modulo NUM_WF.
  - On a grant: next cycle arb_valid=1, arb_wfid=winner, arb_second_half=0; last_grant←winner; go to CHECK.
  - If no bit is set: arb_valid=0 next cycle; stay in ARB.
- CHECK (the cycle in which the granted dword sits in decode's input flops):
  - arb_valid=0.
  - If wave_ins_half_rqd=1 and wave_ins_half_wfid==last_grant: go to SECOND.
  - If wave_ins_half_rqd=1 with a different wfid: set arb_error; go to ARB.
  - Otherwise go to ARB. No new first-dword grant is issued from CHECK.
- SECOND:
  - If wave_ready[last_grant]=1: next cycle arb_valid=1, arb_wfid=last_grant, arb_second_half=1; go to CHECK with second_pending=1.
  - If wave_ready[last_grant]=0: arb_valid=0; remain in SECOND indefinitely. Other wavefronts are never granted while in SECOND.
- CHECK entered after a second-half grant (second_pending=1):
  - wave_ins_half_rqd is ignored; arb_error is not set.
  - Go to ARB; clear second_pending.
- last_grant is not updated by a second-half grant.
- arb_wfid is the zero-extended winner index; wfids ≥ NUM_WF are never produced.
- wave_ins_half_wfid ≥ NUM_WF in CHECK counts as a mismatch (sets arb_error).
- arb_error clears only on rst.

## Timing
- Reset values: state=ARB; last_grant=NUM_WF-1, so wave 0 has first priority; second_pending=0; arb_valid=0; arb_wfid=0; arb_second_half=0; arb_error=0.
- rst asserted mid-operation (any state) forces the reset values on the next edge; a pending second half is dropped.
- All outputs are flops; there is no combinational path from inputs to outputs.
- Grant latency: wave_ready sampled at edge n in ARB → arb_valid high during cycle n+1.
- Short instruction throughput: one grant per 2 cycles (grant, CHECK).
- Long instruction: first grant at cycle t, CHECK at t+1, second grant at t+2 if wave_ready stays high, CHECK at t+3, next first-dword grant no earlier than t+4.
- wave_ins_half_rqd is sampled only in CHECK; it is ignored in ARB and SECOND.
- Wrap-around: with last_grant=NUM_WF-1, the scan starts at 0.
- The scan includes last_grant itself as the final candidate, so a single ready wave is re-granted every 2 cycles.

## Test plan
- Reset, then wave_ready=bit 0 only, held high: arb_valid pulses on cycles 1, 3, 5 with arb_wfid=0, arb_second_half=0.
- wave_ready = bits 3, 7 and 39, held high: grant order 3, 7, 39, 3, 7 (wrap-around), one grant every 2 cycles.
- Grant wfid 5; in CHECK drive half_rqd=1, half_wfid=5: cycle t+2 arb_valid=1, arb_wfid=5, arb_second_half=1; next grant at t+4 goes to the next ready wave above 5.
- After the first half of wfid 5: drop wave_ready[5] for 3 cycles while wave 9 is ready: no grants during those cycles; wave_ready[5] rises → second-half grant of 5, then wave 9 is granted.
- In CHECK after a grant to wfid 2, drive half_rqd=1, half_wfid=4: arb_error=1 from the next cycle and stays 1; the arbiter returns to ARB with no second-half grant.
- Assert rst while in SECOND: the next cycle has all outputs 0, state ARB, and wave 0 wins if ready.
